// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the CPU execute stage (cpu_*)
//   and a debug/loader port (dbg_*). Each requester uses a req/gnt handshake.
//   Reads return data with a one-cycle rvalid pulse. The memory has registered
//   read data, so rdata is valid the cycle after the read strobe is sampled.
//
//   FSM: IDLE -> ISSUE -> (write) IDLE
//                       -> (read)  RESP -> IDLE
//   A request is latched when it is accepted in IDLE. Strobes, gnt and rvalid
//   are registered and high for exactly one cycle per transaction.
//
//   Configuration macro:
//     DMEM_ARB_RR_EN  defined   : round-robin between cpu and dbg when both
//                                 request (last_winner resets to DBG).
//                     undefined : fixed priority, CPU wins.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i    CPU request (held until cpu_gnt_o)
//   cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o   CPU grant pulse, read response
//   dbg_*                   same as cpu_* for the debug/loader port
//   mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o   registered memory drive
//   mem_rdata_i             memory read data (one cycle after read strobe)
//   busy_o                  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_gnt_o,
  output logic          dbg_rvalid_o,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            win_dbg_q, win_dbg_d;   // winner of the in-flight op: 1=dbg
  logic            we_q, we_d;             // latched direction of in-flight op
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            cpu_gnt_q, cpu_gnt_d;
  logic            dbg_gnt_q, dbg_gnt_d;
  logic            cpu_rvalid_q, cpu_rvalid_d;
  logic            dbg_rvalid_q, dbg_rvalid_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic            pick_dbg;

`ifdef DMEM_ARB_RR_EN
  logic            last_dbg_q, last_dbg_d; // last winner: 1=dbg, 0=cpu

  // Both requesting: grant whoever did not win last time.
  always_comb begin
    pick_dbg = dbg_req_i && (!cpu_req_i || !last_dbg_q);
  end
`else
  // Fixed priority: dbg only wins when the CPU is not requesting.
  always_comb begin
    pick_dbg = dbg_req_i && !cpu_req_i;
  end
`endif

  // NOTE: every variable gets a default at the top of the combinational block
  // so that no path through the case statement leaves it unassigned (latch).
  always_comb begin
    state_d      = state_q;
    win_dbg_d    = win_dbg_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
`ifdef DMEM_ARB_RR_EN
    last_dbg_d   = last_dbg_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cpu_req_i || dbg_req_i) begin
          // Latch the winner's request; the registered strobes/gnt then
          // become visible during the ISSUE cycle.
          win_dbg_d   = pick_dbg;
          we_d        = pick_dbg ? dbg_we_i    : cpu_we_i;
          mem_addr_d  = pick_dbg ? dbg_addr_i  : cpu_addr_i;
          mem_wdata_d = pick_dbg ? dbg_wdata_i : cpu_wdata_i;
          mem_write_d = we_d;
          mem_read_d  = !we_d;
          cpu_gnt_d   = !pick_dbg;
          dbg_gnt_d   = pick_dbg;
`ifdef DMEM_ARB_RR_EN
          last_dbg_d  = pick_dbg;
`endif
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        // Memory read data is valid now; capture it at the closing edge and
        // raise the winner's rvalid for the following (IDLE) cycle.
        if (win_dbg_q) begin
          dbg_rdata_d  = mem_rdata_i;
          dbg_rvalid_d = 1'b1;
        end else begin
          cpu_rdata_d  = mem_rdata_i;
          cpu_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      win_dbg_q    <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      last_dbg_q   <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      win_dbg_q    <= win_dbg_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
`ifdef DMEM_ARB_RR_EN
      last_dbg_q   <= last_dbg_d;
`endif
    end
  end

  assign cpu_gnt_o    = cpu_gnt_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign dbg_gnt_o    = dbg_gnt_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_rdata_o  = dbg_rdata_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed and randomized stimulus for dmem_arbiter. A 16-word memory
//   device sits on the mem_* port; the expected behaviour comes from a
//   reference word array and fixed transaction latencies (gnt one edge after
//   acceptance, write committed at the second edge, rvalid after the third).
//   Compile with +define+DMEM_ARB_RR_EN to check round-robin arbitration.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem     [16];   // memory device on the mem_* port
  logic [31:0] ref_mem [16];   // expected memory contents
  bit          last_dbg;       // expected last winner (1 = dbg)
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_gnt_o    (cpu_gnt),
    .cpu_rvalid_o (cpu_rvalid),
    .cpu_rdata_o  (cpu_rdata),
    .dbg_req_i    (dbg_req),
    .dbg_we_i     (dbg_we),
    .dbg_addr_i   (dbg_addr),
    .dbg_wdata_i  (dbg_wdata),
    .dbg_gnt_o    (dbg_gnt),
    .dbg_rvalid_o (dbg_rvalid),
    .dbg_rdata_o  (dbg_rdata),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .busy_o       (busy)
  );

  // Single-port memory with registered read data.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[3:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   {31'd0, busy}, 0);
    check({tag, "_gnt"},    {30'd0, cpu_gnt, dbg_gnt}, 0);
    check({tag, "_rvalid"}, {30'd0, cpu_rvalid, dbg_rvalid}, 0);
    check({tag, "_strobe"}, {30'd0, mem_read, mem_write}, 0);
    check({tag, "_addr"},   mem_addr, 0);
    check({tag, "_wdata"},  mem_wdata, 0);
    check({tag, "_rdata"},  cpu_rdata | dbg_rdata, 0);
  endtask

  // One transaction from a single side, starting with the DUT in IDLE.
  task automatic op(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd);
    string s = d ? "dbg" : "cpu";
    if (d) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    end
    tick();                                   // edge 1: accepted
    check({s, "_gnt"},       {31'd0, d ? dbg_gnt : cpu_gnt}, 1);
    check({s, "_other_gnt"}, {31'd0, d ? cpu_gnt : dbg_gnt}, 0);
    check({s, "_mem_write"}, {31'd0, mem_write}, {31'd0, we});
    check({s, "_mem_read"},  {31'd0, mem_read}, {31'd0, !we});
    check({s, "_mem_addr"},  mem_addr, a);
    if (we) check({s, "_mem_wdata"}, mem_wdata, wd);
    last_dbg = d;
    if (d) dbg_req = 1'b0; else cpu_req = 1'b0;
    tick();                                   // edge 2: issued
    check({s, "_gnt_pulse"},    {30'd0, cpu_gnt, dbg_gnt}, 0);
    check({s, "_strobe_pulse"}, {30'd0, mem_read, mem_write}, 0);
    if (we) begin
      ref_mem[a[3:0]] = wd;
      check({s, "_busy_after_wr"}, {31'd0, busy}, 0);
      check({s, "_no_rvalid_wr"}, {30'd0, cpu_rvalid, dbg_rvalid}, 0);
    end else begin
      check({s, "_busy_resp"}, {31'd0, busy}, 1);
      check({s, "_early_rvalid"}, {30'd0, cpu_rvalid, dbg_rvalid}, 0);
      tick();                                 // edge 3: response
      check({s, "_rvalid"},       {31'd0, d ? dbg_rvalid : cpu_rvalid}, 1);
      check({s, "_other_rvalid"}, {31'd0, d ? cpu_rvalid : dbg_rvalid}, 0);
      check({s, "_rdata"},        d ? dbg_rdata : cpu_rdata, ref_mem[a[3:0]]);
      check({s, "_busy_idle"},    {31'd0, busy}, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    mem[2] = 32'd30; ref_mem[2] = 32'd30;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    last_dbg = 1'b1;

    // Reset values.
    rst = 1'b1;
    #2;
    check_all_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    // dbg read of preset word; cpu side must stay quiet.
    op(1'b1, 1'b0, 32'd2, 32'd0);
    check("t2_cpu_rdata", cpu_rdata, 0);
    check("t2_cpu_rvalid", {31'd0, cpu_rvalid}, 0);

    // CPU write then read back.
    op(1'b0, 1'b1, 32'd3, 32'h55);
    op(1'b0, 1'b0, 32'd3, 32'd0);
    check("t1_rdata_55", cpu_rdata, 32'h55);

    // Both requesting, 4 write transactions.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'd8; cpu_wdata = 32'hC0DE_0008;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'd9; dbg_wdata = 32'hDB60_0009;
    for (int i = 0; i < 4; i++) begin
      bit exp_d;
`ifdef DMEM_ARB_RR_EN
      exp_d = !last_dbg;
`else
      exp_d = 1'b0;
`endif
      tick();
      check("t3_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, !exp_d});
      check("t3_dbg_gnt", {31'd0, dbg_gnt}, {31'd0, exp_d});
      last_dbg = exp_d;
      if (exp_d) ref_mem[9] = dbg_wdata; else ref_mem[8] = cpu_wdata;
      tick();
      check("t3_busy_gap", {31'd0, busy}, 0);
    end
    cpu_req = 0; dbg_req = 0;
    op(1'b0, 1'b0, 32'd8, 32'd0);
    op(1'b1, 1'b0, 32'd9, 32'd0);

    // Back-to-back CPU writes with req kept high.
    cpu_req = 1; cpu_we = 1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = i; cpu_wdata = 32'hA000 + i;
      tick();
      check("t4_mem_write", {31'd0, mem_write}, 1);
      check("t4_addr", mem_addr, i);
      check("t4_busy", {31'd0, busy}, 1);
      ref_mem[i] = 32'hA000 + i;
      tick();
      check("t4_write_gap", {31'd0, mem_write}, 0);
      check("t4_busy_gap", {31'd0, busy}, 0);
    end
    cpu_req = 0;
    last_dbg = 1'b0;
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, i, 32'd0);

    // Reset during RESP of a dbg read.
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'd2;
    tick();
    check("t5_dbg_gnt", {31'd0, dbg_gnt}, 1);
    dbg_req = 0;
    tick();
    check("t5_in_resp", {31'd0, busy}, 1);
    #1 rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    tick();
    rst = 1'b0;
    last_dbg = 1'b1;
    tick();
    check("t5_no_rvalid", {31'd0, dbg_rvalid}, 0);
    check("t5_idle", {31'd0, busy}, 0);
    tick();
    check("t5_no_rvalid2", {31'd0, dbg_rvalid}, 0);

    // Write whose req is held for only the accepting edge: still completes.
    op(1'b0, 1'b1, 32'd12, 32'h1234_5678);
    tick();
    check("t6_no_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 0);
    op(1'b1, 1'b0, 32'd12, 32'd0);

    // Randomized single-side traffic with random idle gaps.
    for (int n = 0; n < 60; n++) begin
      bit          d  = 1'($urandom_range(0, 1));
      bit          we = 1'($urandom_range(0, 1));
      logic [31:0] a  = $urandom_range(0, 15);
      logic [31:0] wd = $urandom;
      int          gap = $urandom_range(0, 2);
      op(d, we, a, wd);
      for (int g = 0; g < gap; g++) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule
